// File: rtl/reqack_arbiter_if.sv
// Handshake bundle for reqack_arbiter.
//   Requester side : src_req, src_data (in); src_done, src_err (out)
//   Channel side   : req, data_a (out); ack_s (in)
//   Status         : busy, grant_id (out)
// Modport slave is the arbiter's view; master is the view of whatever drives requests and acks.
interface reqack_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            src_req;
  logic [NUM_REQ*DATA_WIDTH-1:0] src_data;
  logic [NUM_REQ-1:0]            src_done;
  logic [NUM_REQ-1:0]            src_err;
  logic                          req;
  logic [DATA_WIDTH-1:0]         data_a;
  logic                          ack_s;
  logic                          busy;
  logic [IdW-1:0]                grant_id;

  modport slave (
    input  src_req, src_data, ack_s,
    output src_done, src_err, req, data_a, busy, grant_id
  );

  modport master (
    output src_req, src_data, ack_s,
    input  src_done, src_err, req, data_a, busy, grant_id
  );
endinterface

// File: rtl/reqack_arbiter.sv
// Round-robin arbiter sharing one req/ack clock-crossing channel between NUM_REQ requesters.
// A winner's data word is captured into data_a, a single-cycle req pulse is issued, and the
// arbiter waits up to TIMEOUT cycles for ack_s. Completion is reported per requester as a
// one-cycle src_done (acked) or src_err (timed out) pulse. Only one transfer is outstanding.
// Ports:
//   clk    : clock, all logic on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : reqack_arbiter_if.slave (src_req/src_data/ack_s in; src_done/src_err/req/data_a/
//            busy/grant_id out). All outputs are registered.
module reqack_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic             clk,
  input logic             rst_n,
  reqack_arbiter_if.slave bus
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                state_q, state_d;
  logic [IdW-1:0]        last_q, last_d;
  logic [IdW-1:0]        grant_q, grant_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_q, req_d;
  logic                  busy_q, busy_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    err_q, err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  // Per-requester data words.
  logic [DATA_WIDTH-1:0] src_words [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign src_words[gi] = bus.src_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first set request starting at last_q+1, wrapping modulo NUM_REQ.
  // The wrap is a conditional subtract so NUM_REQ need not be a power of two.
  logic           win_found;
  logic [IdW-1:0] win_id;
  logic [IdW:0]   rr_sum;
  logic [IdW-1:0] rr_idx;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      rr_sum = {1'b0, last_q} + (IdW+1)'(k);
      if (rr_sum >= (IdW+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (IdW+1)'(NUM_REQ);
      end
      rr_idx = rr_sum[IdW-1:0];
      if (!win_found && bus.src_req[rr_idx]) begin
        win_found = 1'b1;
        win_id    = rr_idx;
      end
    end
  end

  // Next-state and registered-output logic. data_a and grant_id only change on a grant so the
  // far domain can sample data_a at any time before the next grant.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    req_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = '0;
    err_d   = '0;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d = win_id;
          data_d  = src_words[win_id];
          req_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // Ack is checked first so a coincident ack and timeout reports done, not err.
        if (bus.ack_s) begin
          done_d[grant_q] = 1'b1;
          last_d          = grant_q;
          busy_d          = 1'b0;
          state_d         = StIdle;
        end else if (cnt_q == CntLast) begin
          err_d[grant_q] = 1'b1;
          last_d         = grant_q;
          busy_d         = 1'b0;
          state_d        = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= IdW'(NUM_REQ - 1);  // first search then starts at index 0
      grant_q <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req      = req_q;
  assign bus.data_a   = data_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
  assign bus.src_done = done_q;
  assign bus.src_err  = err_q;

endmodule
